// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: MMIO register bus between the processor decode and the display controller
// Signals: we (write strobe), addr (register select), wdata (store data), rdata (combinational readback)
// Modports: master drives we/addr/wdata and reads rdata; slave is the controller side
interface seg7_scan_ctrl_if;
  logic        we;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  modport master (output we, addr, wdata, input rdata);
  modport slave (input we, addr, wdata, output rdata);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 4-digit seven-segment driver with tear-free frame reload
// Ports: clk, rst (async active-high), bus (slave: we/addr/wdata/rdata),
//        seg[6:0] active-low {g..a}, an[3:0] active-low anodes (an[0] rightmost), frame_tick
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to add CTRL[5] leading-zero blanking
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  seg7_scan_ctrl_if.slave bus,
  output logic [6:0]      seg,
  output logic [3:0]      an,
  output logic            frame_tick
);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam int CW = 6;
`else
  localparam int CW = 5;
`endif
  localparam int MAXC = REFRESH_DIV > BLANK_CYCLES ? (REFRESH_DIV > 2 ? REFRESH_DIV : 2)
                                                   : (BLANK_CYCLES > 2 ? BLANK_CYCLES : 2);
  localparam int CNTW = $clog2(MAXC);
  localparam logic [CNTW-1:0] SHOW_LAST  = CNTW'(REFRESH_DIV - 1);
  // Wraps to all-ones when BLANK_CYCLES is 0; BLANK is never entered then.
  localparam logic [CNTW-1:0] BLANK_LAST = CNTW'(BLANK_CYCLES - 1);
  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef enum logic [1:0] {SHOW, BLANK, ADVANCE} state_t;
  state_t          state_q, state_d;
  logic [15:0]     value_q, value_d;
  logic [CW-1:0]   ctrl_q, ctrl_d;
  logic [15:0]     disp_q, disp_d;
  logic [1:0]      idx_q, idx_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            ft_q, ft_d;
  logic            wr_value;
  logic            lz_blank;
  logic            lit;
  logic [3:0]      digit;
  assign bus.rdata  = bus.addr == 2'd0 ? value_q : bus.addr == 2'd1 ? 16'(ctrl_q) : 16'd0;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = ft_q;
  always_comb begin
    value_d  = value_q;
    ctrl_d   = ctrl_q;
    disp_d   = disp_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    ft_d     = 1'b0;
    wr_value = bus.we && bus.addr == 2'd0;
    if (wr_value) value_d = bus.wdata;
    if (bus.we && bus.addr == 2'd1) ctrl_d = bus.wdata[CW-1:0];
    case (state_q)
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          if (BLANK_CYCLES == 0) state_d = ADVANCE;
          else state_d = BLANK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = ADVANCE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        idx_d   = idx_q + 1'b1;
        state_d = SHOW;
        if (idx_q == 2'd3) begin
          ft_d = 1'b1;
          // A VALUE store landing on the reload cycle is forwarded so it is not lost for a frame.
          if (!ctrl_q[4]) disp_d = wr_value ? bus.wdata : value_q;
        end
      end
    endcase
  end
  always_comb begin
    digit = disp_q[{idx_q, 2'b00} +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Blank when this digit and all more-significant ones are zero; digit 0 always survives.
    lz_blank = ctrl_q[5] && idx_q != 2'd0 && (disp_q >> {idx_q, 2'b00}) == 16'd0;
`else
    lz_blank = 1'b0;
`endif
    lit  = state_q == SHOW && ctrl_q[idx_q] && !lz_blank;
    an_d  = lit ? ~(4'b0001 << idx_q) : 4'b1111;
    seg_d = lit ? HEX[digit] : 7'b1111111;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SHOW;
      value_q <= 16'd0;
      ctrl_q  <= CW'(5'b01111);
      disp_q  <= 16'd0;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      seg_q   <= 7'b1111111;
      an_q    <= 4'b1111;
      ft_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      ctrl_q  <= ctrl_d;
      disp_q  <= disp_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      ft_q    <= ft_d;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: table vectors, directed corner sequences and random stores against a frame-arithmetic model
module tb_seg7_scan_ctrl;
  localparam int RD = 4;
  localparam int BC = 1;
  localparam int S  = RD + BC + 1;
  localparam int F  = 4 * S;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [5:0] CMASK = 6'h3F;
`else
  localparam logic [5:0] CMASK = 6'h1F;
`endif
  localparam logic [6:0] HEXM [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] seg;
  logic [3:0] an;
  logic frame_tick;
  int tests = 0;
  int fails = 0;
  int t = 0;
  int pulses = 0;
  logic [15:0] m_value = 16'd0;
  logic [15:0] m_disp = 16'd0;
  logic [5:0]  m_ctrl = 6'h0F;
  vec_t vecs [8];
  seg7_scan_ctrl_if bus ();
  seg7_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .bus(bus), .seg(seg), .an(an), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
    end
  endtask
  // Model: state of cycle t is located purely by its position in the frame.
  task automatic tick(input logic w, input logic [1:0] a, input logic [15:0] d);
    int slot, pos;
    logic lit, e_ft;
    logic [3:0] dig, e_an;
    logic [6:0] e_seg;
    bus.we = w;
    bus.addr = a;
    bus.wdata = d;
    slot = (t % F) / S;
    pos = t % S;
    dig = 4'((m_disp >> (4 * slot)) & 16'hF);
    lit = pos < RD && m_ctrl[slot] && !(m_ctrl[5] && slot != 0 && (m_disp >> (4 * slot)) == 16'd0);
    e_an = lit ? 4'(~(4'b0001 << slot)) : 4'b1111;
    e_seg = lit ? HEXM[dig] : 7'b1111111;
    e_ft = (t % F) == F - 1;
    if (e_ft && !m_ctrl[4]) m_disp = (w && a == 2'd0) ? d : m_value;
    if (w && a == 2'd0) m_value = d;
    if (w && a == 2'd1) m_ctrl = d[5:0] & CMASK;
    t++;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    if (frame_tick === 1'b1) pulses++;
    check("an", 16'(an), 16'(e_an));
    check("seg", 16'(seg), 16'(e_seg));
    check("frame_tick", 16'(frame_tick), 16'(e_ft));
  endtask
  task automatic run(input int n);
    repeat (n) tick(1'b0, 2'd0, 16'd0);
  endtask
  initial begin
    int p0;
    logic [1:0] ra;
    logic [15:0] rd, rexp;
    vecs[0] = '{1'b1, 2'd0, 16'h7D03, 16'h7D03};
    vecs[1] = '{1'b1, 2'd1, 16'hFFC5, 16'h0005};
    vecs[2] = '{1'b1, 2'd2, 16'hBEEF, 16'h0000};
    vecs[3] = '{1'b1, 2'd3, 16'h1111, 16'h0000};
    vecs[4] = '{1'b0, 2'd0, 16'h0000, 16'h7D03};
    vecs[5] = '{1'b0, 2'd1, 16'h0000, 16'h0005};
    vecs[6] = '{1'b1, 2'd1, 16'h002F, 16'(6'h2F & CMASK)};
    vecs[7] = '{1'b1, 2'd1, 16'h000F, 16'h000F};
    bus.we = 1'b0;
    bus.addr = 2'd0;
    bus.wdata = 16'd0;
    #30;
    check("rst_an", 16'(an), 16'hF);
    check("rst_seg", 16'(seg), 16'h7F);
    check("rst_ft", 16'(frame_tick), 16'h0);
    check("rst_value", bus.rdata, 16'h0000);
    bus.addr = 2'd1;
    #1;
    check("rst_ctrl", bus.rdata, 16'h000F);
    bus.addr = 2'd0;
    #19;
    rst = 1'b0;
    tick(1'b0, 2'd0, 16'd0);
    tick(1'b0, 2'd0, 16'd0);
    check("second_edge_an", 16'(an), 16'hE);
    check("second_edge_seg", 16'(seg), 16'h40);
    run(10);
    for (int i = 0; i < 8; i++) begin
      tick(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check("rdata_vec", bus.rdata, vecs[i].exp);
    end
    run(2 * F);
    tick(1'b1, 2'd1, 16'h0005);
    run(2 * F);
    tick(1'b1, 2'd1, 16'h001F);
    tick(1'b1, 2'd0, 16'h1234);
    p0 = pulses;
    run(3 * F);
    check("freeze_ticks", 16'(pulses - p0), 16'd3);
    tick(1'b1, 2'd1, 16'h000F);
    run(2 * F);
    while (t % F != F - 1) tick(1'b0, 2'd0, 16'd0);
    tick(1'b1, 2'd0, 16'hABCD);
    tick(1'b0, 2'd0, 16'd0);
    check("bypass_an", 16'(an), 16'hE);
    check("bypass_seg", 16'(seg), 16'(7'b0100001));
    run(F);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        ra = 2'($urandom_range(0, 3));
        rd = 16'($urandom);
        tick(1'b1, ra, rd);
        rexp = ra == 2'd0 ? m_value : ra == 2'd1 ? 16'(m_ctrl) : 16'd0;
        check("rdata_rand", bus.rdata, rexp);
      end else begin
        tick(1'b0, 2'd0, 16'd0);
      end
    end
    tick(1'b1, 2'd1, 16'h000F);
    run(F);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    tick(1'b1, 2'd1, 16'h002F);
    tick(1'b1, 2'd0, 16'h0050);
    while (t % F != 0) tick(1'b0, 2'd0, 16'd0);
    run(S + 1);
    check("lzb_digit1", 16'(seg), 16'(7'b0010010));
    run(2 * F);
    tick(1'b1, 2'd0, 16'h0000);
    run(2 * F);
    tick(1'b1, 2'd1, 16'h000F);
    run(F);
`endif
    tick(1'b1, 2'd0, 16'h5A5A);
    while (t % F != 2 * S + RD) tick(1'b0, 2'd0, 16'd0);
    rst = 1'b1;
    #1;
    check("midrst_an", 16'(an), 16'hF);
    check("midrst_seg", 16'(seg), 16'h7F);
    check("midrst_ft", 16'(frame_tick), 16'h0);
    check("midrst_value", bus.rdata, 16'h0000);
    t = 0;
    m_value = 16'd0;
    m_disp = 16'd0;
    m_ctrl = 6'h0F;
    #2;
    rst = 1'b0;
    run(2 * F);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Memory-mapped controller for the shared 4-digit seven-segment display of the processor top level.
- Accepts processor stores into a value register and a control register.
- Time-multiplexes the single seg bus across the four anodes with a blanking gap between digits, and reloads the displayed value only at frame boundaries so there is no tearing.
- Sits between the processor's MMIO decode and the board seg/an pins.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit is driven (1 kHz per digit at 100 MHz); minimum 1.
- BLANK_CYCLES, 16, cycles with all anodes off between digits; 0 disables the blank phase.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset (debounced btnC).
- we  input  1  MMIO write strobe, sampled on the clk rising edge.
- addr  input  2  register select: 0 = VALUE, 1 = CTRL, 2/3 = reserved.
- wdata  input  16  write data.
- rdata  output  16  combinational readback of the selected register.
- seg  output  7  active-low segments {g,f,e,d,c,b,a}; registered.
- an  output  4  active-low anodes; an[0] = rightmost digit, carries VALUE[3:0]; registered.
- frame_tick  output  1  one-cycle pulse when the display register reloads.

Behaviour:
- Registers:
  - VALUE[15:0]: reset 0. Updated on the edge where we=1 and addr=0.
  - CTRL: reset 5'b0_1111. Updated on the edge where we=1 and addr=1, from wdata[4:0]. Bits [3:0] = digit enable mask; bit 4 = freeze.
  - Writes to addr 2/3 are ignored.
- Readback: rdata = VALUE for addr 0; {11'b0,CTRL} for addr 1; 0 otherwise. Reflects a write on the following cycle.
- Internal state: disp_reg[15:0] (reset 0), digit index idx[1:0] (reset 0), cycle counter cnt (reset 0), FSM state.
- FSM states:
  - SHOW: cnt counts 0..REFRESH_DIV-1. At the terminal count, cnt clears and the FSM goes to BLANK, or directly to ADVANCE if BLANK_CYCLES=0.
  - BLANK: cnt counts 0..BLANK_CYCLES-1. At the terminal count, cnt clears and the FSM goes to ADVANCE.
  - ADVANCE: single cycle. idx increments modulo 4; the FSM goes to SHOW.
    - When idx wraps 3->0 and freeze=0: disp_reg loads VALUE and frame_tick=1.
    - If the same cycle is a VALUE write, disp_reg loads wdata (write bypass).
    - With freeze=1, disp_reg holds; frame_tick still pulses on wrap.
- Frame length: 4*(REFRESH_DIV+BLANK_CYCLES+1) cycles.
- Outputs are registered from the current-cycle state (one-cycle delay):
  - SHOW with mask[idx]=1: an = one-cold at idx; seg = hex decode of disp_reg[4*idx+3:4*idx].
  - SHOW with mask[idx]=0: an = 4'b1111, seg = 7'b1111111. The slot time is still consumed, so frame rate stays constant.
  - BLANK/ADVANCE: an = 4'b1111, seg = 7'b1111111.
- Hex decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Reset values of outputs: an=4'b1111, seg=7'b1111111, frame_tick=0, rdata reflects reset register values.
  - The first cycle after rst deasserts is SHOW, idx 0; an=1110 and seg=1000000 appear on the following edge.
- Reset mid-operation: asynchronous. All registers and outputs return to reset values immediately, regardless of FSM state or counter value.
- The counter is sized to clog2(max(REFRESH_DIV,BLANK_CYCLES,2)) bits; no overflow is possible.

Optional Feature:
- Macro SEG7_LEADING_ZERO_BLANK_EN.
- When defined, CTRL gains bit 5 (lzb; reset 0, written from wdata[5], readback bit 5).
  - With lzb=1, a digit is blanked (an bit high, seg=1111111) when it and every more-significant digit of disp_reg are zero.
  - Digit 0 is never blanked by this rule; the enable mask still applies.
- When undefined, bit 5 is not implemented: writes are ignored, it reads 0, and behaviour is exactly as above.

Test Plan (REFRESH_DIV=4, BLANK_CYCLES=1, frame = 24 cycles):
- Reset: hold rst 50 ns, release -> an=1111 and seg=1111111 during reset; an=1110, seg=1000000 on the second edge after release; frame_tick first pulses 24 cycles later.
- Write VALUE=16'h7D03 mid-frame -> rdata=7D03 next cycle; display unchanged until wrap; then digits show 3 (0110000), 0, D (0100001), 7 (1111000) on an 1110, 1101, 1011, 0111; an=1111 for 1 BLANK plus 1 ADVANCE cycle between digits.
- Write CTRL=5'b0_0101 -> slots 1 and 3 show an=1111 but still last 6 cycles; slots 0 and 2 are active; frame stays 24 cycles.
- Set freeze (CTRL=5'b1_1111), write VALUE=16'h1234 -> display keeps the old value across 3 frames with frame_tick still pulsing; clearing freeze -> 1234 appears after the next wrap.
- Write VALUE=16'hABCD exactly on the ADVANCE 3->0 cycle -> disp_reg=ABCD in that same frame (bypass); assert rst while in BLANK of idx 2 -> an=1111 immediately, idx=0, VALUE=0.
- With SEG7_LEADING_ZERO_BLANK_EN, lzb=1, VALUE=16'h0050 -> digits 3 and 2 are blanked; digit 1 shows 5; digit 0 shows 0. With VALUE=0 -> only digit 0 is lit, showing 0.
